// File: rtl/mmu_table_loader.sv
// Fills the 256x8 MMU mapping RAM with the default translation map after reset,
// and refills a single task on request through a START/BUSY/DONE handshake.
module mmu_table_loader #(
    parameter int         WR_CYCLES = 2,
    parameter logic [1:0] RAM_SEL   = 2'b10,
    parameter logic [1:0] ROM_SEL   = 2'b00,
    parameter bit         BOOT_FILL = 1'b1
) (
    input  logic       CLKX4,
    input  logic       RESET,
    input  logic       START,
    input  logic [4:0] TASK,
    output logic       BUSY,
    output logic       DONE,
    output logic       CPU_nRESET,
    output logic       RAM_OWN,
    output logic [7:0] RAM_ADDR,
    output logic [7:0] RAM_DATA,
    output logic       RAM_DATA_OE,
    output logic       RAM_nWR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_NEXT,
        ST_BOOT_INIT
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(WR_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       boot_mode_reg, boot_mode_next;
    logic [3:0] strobe_cnt_reg, strobe_cnt_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       cpu_nreset_reg, cpu_nreset_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] data_reg, data_next;
    logic       oe_reg, oe_next;
    logic       nwr_reg, nwr_next;
    logic       last_entry;

    // Low-half slots map to RAM, high-half to ROM; bit 5 mirrors slot[0] for identity A13.
    function automatic logic [7:0] entry_of(input logic [2:0] slot);
        return {(slot[2] ? ROM_SEL : RAM_SEL), slot[0], 2'b00, slot};
    endfunction

    assign last_entry = boot_mode_reg ? (ptr_reg == 8'hFF) : (ptr_reg[2:0] == 3'b111);

    always_ff @(posedge CLKX4 or posedge RESET) begin
        if (RESET) begin
            state_reg      <= ST_BOOT_INIT;
            ptr_reg        <= 8'h00;
            boot_mode_reg  <= 1'b0;
            strobe_cnt_reg <= 4'd0;
            busy_reg       <= BOOT_FILL;
            done_reg       <= 1'b0;
            cpu_nreset_reg <= 1'b0;
            addr_reg       <= 8'h00;
            data_reg       <= 8'h00;
            oe_reg         <= 1'b0;
            nwr_reg        <= 1'b1;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            boot_mode_reg  <= boot_mode_next;
            strobe_cnt_reg <= strobe_cnt_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            cpu_nreset_reg <= cpu_nreset_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            oe_reg         <= oe_next;
            nwr_reg        <= nwr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        boot_mode_next  = boot_mode_reg;
        strobe_cnt_next = strobe_cnt_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        cpu_nreset_next = cpu_nreset_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        oe_next         = oe_reg;
        nwr_next        = 1'b1;

        case (state_reg)
            ST_BOOT_INIT: begin
                if (BOOT_FILL) begin
                    ptr_next       = 8'h00;
                    boot_mode_next = 1'b1;
                    state_next     = ST_SETUP;
                    addr_next      = 8'h00;
                    data_next      = entry_of(3'b000);
                    oe_next        = 1'b1;
                    busy_next      = 1'b1;
                end else begin
                    state_next      = ST_IDLE;
                    cpu_nreset_next = 1'b1;
                    busy_next       = 1'b0;
                    oe_next         = 1'b0;
                end
            end
            ST_IDLE: begin
                busy_next = 1'b0;
                oe_next   = 1'b0;
                if (START) begin
                    ptr_next       = {TASK, 3'b000};
                    boot_mode_next = 1'b0;
                    state_next     = ST_SETUP;
                    addr_next      = {TASK, 3'b000};
                    data_next      = entry_of(3'b000);
                    oe_next        = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            ST_SETUP: begin
                state_next      = ST_STROBE;
                strobe_cnt_next = 4'd0;
                nwr_next        = 1'b0;
            end
            ST_STROBE: begin
                if (strobe_cnt_reg == STROBE_LAST) begin
                    state_next = ST_HOLD;
                end else begin
                    strobe_cnt_next = strobe_cnt_reg + 4'd1;
                    nwr_next        = 1'b0;
                end
            end
            ST_HOLD: begin
                // The NEXT decision is folded into this edge so each entry costs WR_CYCLES+2.
                if (last_entry) begin
                    state_next      = ST_IDLE;
                    busy_next       = 1'b0;
                    oe_next         = 1'b0;
                    cpu_nreset_next = 1'b1;
                    done_next       = ~boot_mode_reg;
                end else begin
                    ptr_next   = ptr_reg + 8'd1;
                    state_next = ST_SETUP;
                    addr_next  = ptr_reg + 8'd1;
                    data_next  = entry_of(ptr_reg[2:0] + 3'd1);
                    oe_next    = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                oe_next    = 1'b0;
            end
        endcase
    end

    assign BUSY        = busy_reg;
    assign RAM_OWN     = busy_reg;
    assign DONE        = done_reg;
    assign CPU_nRESET  = cpu_nreset_reg;
    assign RAM_ADDR    = addr_reg;
    assign RAM_DATA    = data_reg;
    assign RAM_DATA_OE = oe_reg;
    assign RAM_nWR     = nwr_reg;

endmodule

// File: tb/tb_mmu_table_loader.sv
// Directed bench for mmu_table_loader: instance 0 uses defaults, instance 1 uses
// WR_CYCLES=1 with the boot fill disabled.
module tb_mmu_table_loader;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] start;
    logic [4:0] tsk [2];
    logic [1:0] busy, done, cpun, own, oe, nwr;
    logic [7:0] addr [2];
    logic [7:0] data [2];
    logic       mon_clr;

    int tests = 0;
    int fails = 0;

    logic [7:0] slot_tbl [8];

    // Write-strobe monitor per instance
    logic [7:0] wr_addr [2][512];
    logic [7:0] wr_data [2][512];
    int         wr_len  [2][512];
    int         wr_n    [2];
    int         low_cnt [2];
    logic [7:0] cur_addr [2];
    logic [7:0] cur_data [2];
    int         busy_cnt [2];
    int         done_cnt [2];

    always #5 clk = ~clk;

    mmu_table_loader dut_a (
        .CLKX4(clk), .RESET(rst[0]), .START(start[0]), .TASK(tsk[0]),
        .BUSY(busy[0]), .DONE(done[0]), .CPU_nRESET(cpun[0]), .RAM_OWN(own[0]),
        .RAM_ADDR(addr[0]), .RAM_DATA(data[0]), .RAM_DATA_OE(oe[0]), .RAM_nWR(nwr[0])
    );

    mmu_table_loader #(.WR_CYCLES(1), .BOOT_FILL(1'b0)) dut_b (
        .CLKX4(clk), .RESET(rst[1]), .START(start[1]), .TASK(tsk[1]),
        .BUSY(busy[1]), .DONE(done[1]), .CPU_nRESET(cpun[1]), .RAM_OWN(own[1]),
        .RAM_ADDR(addr[1]), .RAM_DATA(data[1]), .RAM_DATA_OE(oe[1]), .RAM_nWR(nwr[1])
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mon
            always @(posedge clk) begin
                if (mon_clr) begin
                    wr_n[gi]     <= 0;
                    low_cnt[gi]  <= 0;
                    busy_cnt[gi] <= 0;
                    done_cnt[gi] <= 0;
                end else begin
                    if (busy[gi]) busy_cnt[gi] <= busy_cnt[gi] + 1;
                    if (done[gi]) done_cnt[gi] <= done_cnt[gi] + 1;
                    if (!nwr[gi]) begin
                        low_cnt[gi]  <= low_cnt[gi] + 1;
                        cur_addr[gi] <= addr[gi];
                        cur_data[gi] <= data[gi];
                    end else if (low_cnt[gi] != 0) begin
                        if (wr_n[gi] < 512) begin
                            wr_addr[gi][wr_n[gi]] <= cur_addr[gi];
                            wr_data[gi][wr_n[gi]] <= cur_data[gi];
                            wr_len[gi][wr_n[gi]]  <= low_cnt[gi];
                        end
                        wr_n[gi]    <= wr_n[gi] + 1;
                        low_cnt[gi] <= 0;
                    end
                end
            end
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Counts recorded writes that deviate from the default map starting at base.
    task automatic verify(input int inst, input int first, input int n, input logic [7:0] base,
                          input int len, output int bad);
        logic [7:0] a;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            a = base + 8'(k);
            if (wr_addr[inst][first + k] !== a || wr_data[inst][first + k] !== slot_tbl[a[2:0]]
                || wr_len[inst][first + k] != len)
                bad++;
        end
    endtask

    task automatic wait_cpu(input int inst, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk);
            #1;
            if (cpun[inst]) begin
                cyc = c;
                return;
            end
        end
    endtask

    task automatic wait_done(input int inst, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (done[inst]) begin
                cyc = c;
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    task automatic clear_mon;
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    initial begin
        int cyc, bad, found, dseen;
        logic oe_at_done, nwr_at_done, busy_at_done;
        slot_tbl = '{8'h80, 8'hA1, 8'h82, 8'hA3, 8'h04, 8'h25, 8'h06, 8'h27};
        rst = 2'b11;
        start = 2'b00;
        tsk[0] = 5'd0;
        tsk[1] = 5'd0;
        mon_clr = 1'b1;
        idle_cycles(3);

        // Reset values
        check("rst_busy", {31'd0, busy[0]}, 1);
        check("rst_own", {31'd0, own[0]}, 1);
        check("rst_cpun", {31'd0, cpun[0]}, 0);
        check("rst_done", {31'd0, done[0]}, 0);
        check("rst_nwr", {31'd0, nwr[0]}, 1);
        check("rst_oe", {31'd0, oe[0]}, 0);
        check("rst_addr", {24'd0, addr[0]}, 0);
        check("rst_data", {24'd0, data[0]}, 0);
        check("rst_busy_noboot", {31'd0, busy[1]}, 0);
        mon_clr = 1'b0;

        // Boot fill
        rst[0] = 1'b0;
        wait_cpu(0, cyc);
        check("boot_cpun_cycle", cyc, 1025);
        @(negedge clk);
        check("boot_busy_after", {31'd0, busy[0]}, 0);
        check("boot_writes", wr_n[0], 256);
        verify(0, 0, 256, 8'h00, 2, bad);
        check("boot_map_bad", bad, 0);
        check("boot_data_03", {24'd0, wr_data[0][3]}, 32'hA3);
        check("boot_data_04", {24'd0, wr_data[0][4]}, 32'h04);
        check("boot_data_25", {24'd0, wr_data[0][8'h25]}, 32'h25);
        check("boot_no_done", done_cnt[0], 0);

        // Task 7 refill
        clear_mon();
        start[0] = 1'b1;
        tsk[0] = 5'h07;
        @(negedge clk);
        start[0] = 1'b0;
        tsk[0] = 5'h1F;
        wait_done(0, cyc);
        check("t7_done_cycle", cyc, 32);
        check("t7_busy_at_done", {31'd0, busy[0]}, 0);
        idle_cycles(5);
        check("t7_writes", wr_n[0], 8);
        verify(0, 0, 8, 8'h38, 2, bad);
        check("t7_map_bad", bad, 0);
        check("t7_busy_cycles", busy_cnt[0], 32);
        check("t7_done_pulses", done_cnt[0], 1);
        check("t7_cpun_stays", {31'd0, cpun[0]}, 1);

        // Task 3 with an ignored task 9 request in the middle
        clear_mon();
        start[0] = 1'b1;
        tsk[0] = 5'h03;
        @(negedge clk);
        start[0] = 1'b0;
        idle_cycles(4);
        start[0] = 1'b1;
        tsk[0] = 5'h09;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, cyc);
        idle_cycles(40);
        check("t3_writes", wr_n[0], 8);
        verify(0, 0, 8, 8'h18, 2, bad);
        check("t3_map_bad", bad, 0);
        check("t3_done_pulses", done_cnt[0], 1);

        // START held high: back-to-back fills of task 1
        clear_mon();
        start[0] = 1'b1;
        tsk[0] = 5'h01;
        dseen = 0;
        oe_at_done = 1'bx;
        nwr_at_done = 1'bx;
        busy_at_done = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done[0] && dseen == 0) begin
                dseen = c + 1;
                oe_at_done = oe[0];
                nwr_at_done = nwr[0];
                busy_at_done = busy[0];
            end
        end
        start[0] = 1'b0;
        idle_cycles(50);
        check("hold_first_done_cycle", dseen, 33);
        check("hold_gap_oe", {31'd0, oe_at_done}, 0);
        check("hold_gap_nwr", {31'd0, nwr_at_done}, 1);
        check("hold_gap_busy", {31'd0, busy_at_done}, 0);
        check("hold_writes", wr_n[0], 16);
        verify(0, 0, 8, 8'h08, 2, bad);
        check("hold_fill1_bad", bad, 0);
        verify(0, 8, 8, 8'h08, 2, bad);
        check("hold_fill2_bad", bad, 0);
        check("hold_done_pulses", done_cnt[0], 2);
        check("hold_busy_cycles", busy_cnt[0], 64);

        // Reset in the middle of the strobe for entry 0x80
        rst[0] = 1'b1;
        idle_cycles(2);
        rst[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (addr[0] == 8'h80 && nwr[0] == 1'b0) begin
                found = 1;
                break;
            end
        end
        check("midrst_reached_0x80", found, 1);
        rst[0] = 1'b1;
        mon_clr = 1'b1;
        #1;
        check("midrst_nwr", {31'd0, nwr[0]}, 1);
        check("midrst_oe", {31'd0, oe[0]}, 0);
        check("midrst_cpun", {31'd0, cpun[0]}, 0);
        idle_cycles(2);
        mon_clr = 1'b0;
        rst[0] = 1'b0;
        wait_cpu(0, cyc);
        check("midrst_cpun_cycle", cyc, 1025);
        @(negedge clk);
        check("midrst_writes", wr_n[0], 256);
        verify(0, 0, 256, 8'h00, 2, bad);
        check("midrst_map_bad", bad, 0);

        // Instance with WR_CYCLES=1 and no boot fill
        clear_mon();
        rst[1] = 1'b0;
        #1;
        check("nb_cpun_at_release", {31'd0, cpun[1]}, 0);
        @(negedge clk);
        check("nb_cpun_one_cycle", {31'd0, cpun[1]}, 1);
        check("nb_busy", {31'd0, busy[1]}, 0);
        idle_cycles(10);
        check("nb_no_writes", wr_n[1], 0);
        start[1] = 1'b1;
        tsk[1] = 5'h00;
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1, cyc);
        check("nb_done_cycle", cyc, 24);
        idle_cycles(5);
        check("nb_writes", wr_n[1], 8);
        verify(1, 0, 8, 8'h00, 1, bad);
        check("nb_map_bad", bad, 0);
        check("nb_busy_cycles", busy_cnt[1], 24);
        check("nb_done_pulses", done_cnt[1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
